// File: rtl/tbird_pkg.sv
// rtl/tbird_pkg.sv - shared encodings for the Thunderbird tail-light decoder
package tbird_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_HAZ   = 2'b11;

    localparam logic [5:0] PAT_OFF = 6'b000000;
    localparam logic [5:0] PAT_L1  = 6'b001000;
    localparam logic [5:0] PAT_L2  = 6'b011000;
    localparam logic [5:0] PAT_L3  = 6'b111000;
    localparam logic [5:0] PAT_R1  = 6'b000100;
    localparam logic [5:0] PAT_R2  = 6'b000110;
    localparam logic [5:0] PAT_R3  = 6'b000111;
    localparam logic [5:0] PAT_H1  = 6'b001100;
    localparam logic [5:0] PAT_H2  = 6'b011110;
    localparam logic [5:0] PAT_ALL = 6'b111111;

    typedef enum logic [3:0] {
        ST_IDLE, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3,
        ST_H1, ST_H2, ST_H3, ST_H4, ST_H5
    } state_t;

    typedef enum logic [3:0] {
        FR_OFF, FR_L1, FR_L2, FR_L3, FR_R1, FR_R2, FR_R3,
        FR_H1, FR_H2, FR_ALL, FR_ILLEGAL
    } frame_t;

    // Entry state for a start frame; anything else lands in IDLE.
    function automatic state_t start_state(input frame_t f);
        case (f)
            FR_L1:   return ST_L1;
            FR_R1:   return ST_R1;
            FR_H1:   return ST_H1;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tbird_light_decoder_classify.sv
// rtl/tbird_light_decoder_classify.sv - tbird_frame_classify: lamp pattern to frame code
module tbird_frame_classify
    import tbird_pkg::*;
(
    input  logic [5:0] light,
    output frame_t     frame
);

    always_comb begin
        case (light)
            PAT_OFF: frame = FR_OFF;
            PAT_L1:  frame = FR_L1;
            PAT_L2:  frame = FR_L2;
            PAT_L3:  frame = FR_L3;
            PAT_R1:  frame = FR_R1;
            PAT_R2:  frame = FR_R2;
            PAT_R3:  frame = FR_R3;
            PAT_H1:  frame = FR_H1;
            PAT_H2:  frame = FR_H2;
            PAT_ALL: frame = FR_ALL;
            default: frame = FR_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/tbird_light_decoder.sv
// rtl/tbird_light_decoder.sv - tail-light bus sequence checker/decoder
// Optional per-mode completion counters with TBIRD_SEQ_COUNT_EN.
module tbird_light_decoder
    import tbird_pkg::*;
#(
    parameter int ERR_CNT_W = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [5:0]           light,
    output logic [1:0]           mode,
    output logic                 busy,
    output logic                 seq_done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef TBIRD_SEQ_COUNT_EN
    ,
    output logic [15:0]          left_cnt,
    output logic [15:0]          right_cnt,
    output logic [15:0]          haz_cnt
`endif
);

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    frame_t frame;
    state_t state_q, state_d, adv;
    logic [1:0] mode_q, mode_d, fin_mode;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic exp_ok, fin;
    logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
    logic [15:0] to_q, to_d;
`ifdef TBIRD_SEQ_COUNT_EN
    logic [15:0] lcnt_q, lcnt_d, rcnt_q, rcnt_d, hcnt_q, hcnt_d;
`endif

    tbird_frame_classify u_classify (
        .light (light),
        .frame (frame)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ecnt_d   = ecnt_q;
        to_d     = to_q;
        exp_ok   = 1'b0;
        fin      = 1'b0;
        fin_mode = MODE_OFF;
        adv      = ST_IDLE;
`ifdef TBIRD_SEQ_COUNT_EN
        lcnt_d = lcnt_q;
        rcnt_d = rcnt_q;
        hcnt_d = hcnt_q;
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    adv    = start_state(frame);
                    exp_ok = (frame == FR_OFF) || (adv != ST_IDLE);
                end
                ST_L1: begin exp_ok = (frame == FR_L2);  adv = ST_L2; end
                ST_L2: begin exp_ok = (frame == FR_L3);  adv = ST_L3; end
                ST_L3: begin exp_ok = (frame == FR_OFF); fin = 1'b1; fin_mode = MODE_LEFT; end
                ST_R1: begin exp_ok = (frame == FR_R2);  adv = ST_R2; end
                ST_R2: begin exp_ok = (frame == FR_R3);  adv = ST_R3; end
                ST_R3: begin exp_ok = (frame == FR_OFF); fin = 1'b1; fin_mode = MODE_RIGHT; end
                ST_H1: begin exp_ok = (frame == FR_H2);  adv = ST_H2; end
                ST_H2: begin exp_ok = (frame == FR_ALL); adv = ST_H3; end
                ST_H3: begin exp_ok = (frame == FR_OFF); adv = ST_H4; end
                ST_H4: begin exp_ok = (frame == FR_ALL); adv = ST_H5; end
                ST_H5: begin exp_ok = (frame == FR_OFF); fin = 1'b1; fin_mode = MODE_HAZ; end
                default: begin exp_ok = 1'b0; adv = ST_IDLE; end
            endcase

            // A bad frame that happens to be a start frame begins a new sequence at once.
            if (exp_ok) begin
                state_d = adv;
            end else begin
                state_d = start_state(frame);
                err_d   = 1'b1;
                if (ecnt_q != '1)
                    ecnt_d = ecnt_q + 1'b1;
            end

            if (exp_ok && fin) begin
                done_d = 1'b1;
                mode_d = fin_mode;
                to_d   = '0;
`ifdef TBIRD_SEQ_COUNT_EN
                if (fin_mode == MODE_LEFT  && lcnt_q != 16'hFFFF) lcnt_d = lcnt_q + 16'd1;
                if (fin_mode == MODE_RIGHT && rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
                if (fin_mode == MODE_HAZ   && hcnt_q != 16'hFFFF) hcnt_d = hcnt_q + 16'd1;
`endif
            end else if (to_q != TO_LIM) begin
                to_d = to_q + 16'd1;
                if (to_d == TO_LIM)
                    mode_d = MODE_OFF;
            end

            busy_d = (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
            to_q    <= '0;
`ifdef TBIRD_SEQ_COUNT_EN
            lcnt_q  <= '0;
            rcnt_q  <= '0;
            hcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
            to_q    <= to_d;
`ifdef TBIRD_SEQ_COUNT_EN
            lcnt_q  <= lcnt_d;
            rcnt_q  <= rcnt_d;
            hcnt_q  <= hcnt_d;
`endif
        end
    end

    assign mode      = mode_q;
    assign busy      = busy_q;
    assign seq_done  = done_q;
    assign err       = err_q;
    assign err_count = ecnt_q;
`ifdef TBIRD_SEQ_COUNT_EN
    assign left_cnt  = lcnt_q;
    assign right_cnt = rcnt_q;
    assign haz_cnt   = hcnt_q;
`endif

endmodule

// File: tb/tb_tbird_light_decoder.sv
// tb/tb_tbird_light_decoder.sv - scoreboard bench for tbird_light_decoder
module tb_tbird_light_decoder;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [5:0] light;
    logic [1:0] mode;
    logic       busy, seq_done, err;
    logic [7:0] err_count;
`ifdef TBIRD_SEQ_COUNT_EN
    logic [15:0] left_cnt, right_cnt, haz_cnt;
`endif

    always #5 clk = ~clk;

    tbird_light_decoder #(.ERR_CNT_W(8), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .light     (light),
        .mode      (mode),
        .busy      (busy),
        .seq_done  (seq_done),
        .err       (err),
        .err_count (err_count)
`ifdef TBIRD_SEQ_COUNT_EN
        ,
        .left_cnt  (left_cnt),
        .right_cnt (right_cnt),
        .haz_cnt   (haz_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic        busy;
        logic        done;
        logic        err;
        logic [7:0]  ecnt;
        logic [15:0] lc;
        logic [15:0] rc;
        logic [15:0] hc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: sequences as frame lists, indexed by mode code 1..3.
    logic [5:0] seq_tab [1:3][0:5];
    int         seq_len [1:3];
    int         m_seq, m_idx, m_ecnt, m_to, m_lc, m_rc, m_hc;
    logic [1:0] m_mode;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int start_of(input logic [5:0] f);
        for (int s = 1; s <= 3; s++)
            if (f == seq_tab[s][0]) return s;
        return 0;
    endfunction

    task automatic model_reset();
        m_seq = 0; m_idx = 0; m_ecnt = 0; m_to = 0; m_mode = 2'b00;
        m_lc = 0; m_rc = 0; m_hc = 0;
    endtask

    task automatic model_step(input logic t, input logic [5:0] f, output exp_t e);
        logic ok, done;
        ok = 1'b1;
        done = 1'b0;
        if (t) begin
            if (m_seq == 0) begin
                if (start_of(f) != 0) begin m_seq = start_of(f); m_idx = 1; end
                else if (f != 6'b000000) ok = 1'b0;
            end else if (f == seq_tab[m_seq][m_idx]) begin
                m_idx++;
                if (m_idx == seq_len[m_seq]) begin
                    done = 1'b1;
                    m_mode = m_seq[1:0];
                    if (m_seq == 1 && m_lc < 65535) m_lc++;
                    if (m_seq == 2 && m_rc < 65535) m_rc++;
                    if (m_seq == 3 && m_hc < 65535) m_hc++;
                    m_seq = 0;
                    m_idx = 0;
                end
            end else begin
                ok = 1'b0;
            end
            if (!ok) begin
                if (m_ecnt < 255) m_ecnt++;
                m_seq = start_of(f);
                m_idx = (m_seq != 0) ? 1 : 0;
            end
            if (done) m_to = 0;
            else if (m_to < TO) begin
                m_to++;
                if (m_to == TO) m_mode = 2'b00;
            end
        end
        e.mode = m_mode;
        e.busy = (m_seq != 0);
        e.done = done;
        e.err  = t && !ok;
        e.ecnt = m_ecnt[7:0];
        e.lc   = m_lc[15:0];
        e.rc   = m_rc[15:0];
        e.hc   = m_hc[15:0];
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_val("mode", mode, e.mode);
        check_val("busy", busy, e.busy);
        check_val("seq_done", seq_done, e.done);
        check_val("err", err, e.err);
        check_val("err_count", err_count, e.ecnt);
`ifdef TBIRD_SEQ_COUNT_EN
        check_val("left_cnt", left_cnt, e.lc);
        check_val("right_cnt", right_cnt, e.rc);
        check_val("haz_cnt", haz_cnt, e.hc);
`endif
    endtask

    task automatic step(input logic t, input logic [5:0] f);
        exp_t e;
        tick  = t;
        light = f;
        model_step(t, f, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic frames(input logic [5:0] f [$], input int gap);
        foreach (f[i]) begin
            step(1'b1, f[i]);
            for (int g = 0; g < gap; g++) step(1'b0, 6'b010101);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_mode"}, mode, 2'b00);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_done"}, seq_done, 1'b0);
        check_val({tag, "_err"}, err, 1'b0);
        check_val({tag, "_ecnt"}, err_count, 8'd0);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        tick  = 1'b0;
        light = 6'b000000;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        seq_tab[1] = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b000000, 6'b000000};
        seq_tab[2] = '{6'b000100, 6'b000110, 6'b000111, 6'b000000, 6'b000000, 6'b000000};
        seq_tab[3] = '{6'b001100, 6'b011110, 6'b111111, 6'b000000, 6'b111111, 6'b000000};
        seq_len[1] = 4;
        seq_len[2] = 4;
        seq_len[3] = 6;
        model_reset();

        apply_reset("rst");
        frames('{6'b000000, 6'b000000, 6'b000000, 6'b000000}, 0);

        frames('{6'b001000, 6'b011000, 6'b111000, 6'b000000}, 0);
        check_val("left_mode", mode, 2'b01);

        frames('{6'b001100, 6'b011110, 6'b111111, 6'b000000, 6'b111111, 6'b000000}, 3);
        check_val("haz_mode", mode, 2'b11);

        frames('{6'b000100, 6'b011000, 6'b001000, 6'b011000, 6'b111000, 6'b000000}, 0);
        check_val("resync_mode", mode, 2'b01);
        check_val("resync_ecnt", err_count, 8'd1);

        // Start frame as the offending frame jumps straight into the new sequence.
        frames('{6'b001000, 6'b011000, 6'b000100, 6'b000110, 6'b000111, 6'b000000}, 0);
        check_val("startsync_mode", mode, 2'b10);

        // Mid-HAZARD reset, applied between clock edges.
        frames('{6'b001100, 6'b011110, 6'b111111}, 0);
        check_val("h3_busy", busy, 1'b1);
        sb.delete();
        apply_reset("midrst");

        for (int i = 0; i < 258; i++) step(1'b1, 6'b010101);
        check_val("ecnt_sat", err_count, 8'd255);

        frames('{6'b000100, 6'b000110, 6'b000111, 6'b000000}, 0);
        check_val("right_mode", mode, 2'b10);
        frames('{6'b000000, 6'b000000, 6'b000000}, 0);
        check_val("to_before", mode, 2'b10);
        step(1'b1, 6'b000000);
        check_val("to_after", mode, 2'b00);
        step(1'b0, 6'b000000);
`ifdef TBIRD_SEQ_COUNT_EN
        check_val("right_cnt", right_cnt, 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
